// File: rtl/genius_seq_engine.sv
// Genius game sequence engine: grows an LFSR-derived button sequence each round,
// plays it on the LEDs paced by tick, then checks player presses one at a time.
module genius_seq_engine #(
  parameter int unsigned N_BTN         = 4,
  parameter int unsigned DEPTH         = 16,
  parameter int unsigned TIMEOUT_TICKS = 5,
  parameter int unsigned PTS_W         = 8
) (
  input  logic                            CLOCK_50,
  input  logic                            R,
  input  logic                            start,
  input  logic [15:0]                     seed,
  input  logic                            tick,
  input  logic [N_BTN-1:0]                btn_press,
  output logic [N_BTN-1:0]                leds,
  output logic [$clog2(DEPTH+1)-1:0]      round,
  output logic [PTS_W-1:0]                points,
  output logic                            end_FPGA,
  output logic                            end_User,
  output logic                            match,
  output logic                            end_time,
  output logic                            win,
  output logic                            lose
);

  localparam int unsigned BW = $clog2(N_BTN);
  localparam int unsigned RW = $clog2(DEPTH + 1);
  localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned TW = $clog2(TIMEOUT_TICKS + 1);

  typedef enum logic [2:0] {
    StIdle, StGen, StShowOn, StShowOff, StWaitUser, StWin, StLose
  } state_e;

  state_e            state_q, state_d;
  logic [15:0]       lfsr_q, lfsr_d;
  logic [RW-1:0]     round_q, round_d;
  logic [PTS_W-1:0]  points_q, points_d;
  logic [IW-1:0]     k_q, k_d, u_q, u_d;
  logic [TW-1:0]     t_q, t_d;
  logic [N_BTN-1:0]  leds_q, leds_d;
  logic              end_fpga_q, end_fpga_d;
  logic              end_user_q, end_user_d;
  logic              match_q, match_d;
  logic              end_time_q, end_time_d;
  logic              win_q, win_d;
  logic              lose_q, lose_d;

  logic [BW-1:0]     seq_q [DEPTH];
  logic              seq_we;
  logic [IW-1:0]     seq_waddr;
  logic [BW-1:0]     seq_wdata;

  logic [BW-1:0]     step;
  logic [RW-1:0]     last_idx;
  logic [IW-1:0]     k_nxt;
  logic [TW-1:0]     t_inc;
  logic [N_BTN-1:0]  exp_btn;

  function automatic logic [N_BTN-1:0] onehot(input logic [BW-1:0] v);
    logic [N_BTN-1:0] r;
    r    = '0;
    r[v] = 1'b1;
    return r;
  endfunction

  assign step     = lfsr_q[BW-1:0];
  assign last_idx = round_q - RW'(1);
  assign k_nxt    = k_q + IW'(1);
  assign t_inc    = t_q + TW'(1);
  assign exp_btn  = onehot(seq_q[u_q]);

  always_comb begin
    state_d    = state_q;
    lfsr_d     = lfsr_q;
    round_d    = round_q;
    points_d   = points_q;
    k_d        = k_q;
    u_d        = u_q;
    t_d        = t_q;
    leds_d     = leds_q;
    end_fpga_d = 1'b0;
    end_user_d = 1'b0;
    match_d    = 1'b0;
    end_time_d = end_time_q;
    win_d      = win_q;
    lose_d     = lose_q;
    seq_we     = 1'b0;
    seq_waddr  = round_q[IW-1:0];
    seq_wdata  = step;

    case (state_q)
      StIdle, StWin, StLose: begin
        leds_d = '0;
        if (start) begin
          lfsr_d     = (seed == 16'h0000) ? 16'hACE1 : seed;
          round_d    = '0;
          points_d   = '0;
          win_d      = 1'b0;
          lose_d     = 1'b0;
          end_time_d = 1'b0;
          state_d    = StGen;
        end
      end
      StGen: begin
        seq_we  = 1'b1;
        lfsr_d  = (lfsr_q >> 1) ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
        round_d = round_q + RW'(1);
        k_d     = '0;
        // seq[0] is being written this cycle on the first round, so bypass it
        leds_d  = onehot((round_q == '0) ? step : seq_q[0]);
        state_d = StShowOn;
      end
      StShowOn: begin
        if (tick) begin
          leds_d  = '0;
          state_d = StShowOff;
        end
      end
      StShowOff: begin
        if (tick) begin
          if (RW'(k_q) == last_idx) begin
            end_fpga_d = 1'b1;
            u_d        = '0;
            t_d        = '0;
            state_d    = StWaitUser;
          end else begin
            k_d     = k_nxt;
            leds_d  = onehot(seq_q[k_nxt]);
            state_d = StShowOn;
          end
        end
      end
      StWaitUser: begin
        if (btn_press != '0) begin
          if (btn_press == exp_btn) begin
            t_d = '0;
            if (RW'(u_q) == last_idx) begin
              end_user_d = 1'b1;
              match_d    = 1'b1;
              points_d   = (&points_q) ? points_q : points_q + PTS_W'(1);
              if (round_q == RW'(DEPTH)) begin
                win_d   = 1'b1;
                state_d = StWin;
              end else begin
                state_d = StGen;
              end
            end else begin
              u_d = u_q + IW'(1);
            end
          end else begin
            lose_d  = 1'b1;
            state_d = StLose;
          end
        end else if (tick) begin
          t_d = t_inc;
          if (t_inc == TW'(TIMEOUT_TICKS)) begin
            end_time_d = 1'b1;
            lose_d     = 1'b1;
            state_d    = StLose;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge R) begin
    if (!R) begin
      state_q    <= StIdle;
      lfsr_q     <= 16'h0000;
      round_q    <= '0;
      points_q   <= '0;
      k_q        <= '0;
      u_q        <= '0;
      t_q        <= '0;
      leds_q     <= '0;
      end_fpga_q <= 1'b0;
      end_user_q <= 1'b0;
      match_q    <= 1'b0;
      end_time_q <= 1'b0;
      win_q      <= 1'b0;
      lose_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      lfsr_q     <= lfsr_d;
      round_q    <= round_d;
      points_q   <= points_d;
      k_q        <= k_d;
      u_q        <= u_d;
      t_q        <= t_d;
      leds_q     <= leds_d;
      end_fpga_q <= end_fpga_d;
      end_user_q <= end_user_d;
      match_q    <= match_d;
      end_time_q <= end_time_d;
      win_q      <= win_d;
      lose_q     <= lose_d;
    end
  end

  // Sequence memory contents are don't-care after reset.
  always_ff @(posedge CLOCK_50) begin
    if (seq_we) seq_q[seq_waddr] <= seq_wdata;
  end

  assign leds     = leds_q;
  assign round    = round_q;
  assign points   = points_q;
  assign end_FPGA = end_fpga_q;
  assign end_User = end_user_q;
  assign match    = match_q;
  assign end_time = end_time_q;
  assign win      = win_q;
  assign lose     = lose_q;

endmodule

// File: doc/genius_seq_engine.md
Name: genius_seq_engine

Overview:
- Parametrised sequence engine for the Genius game. It generates a pseudo-random button sequence that grows by one step per round and plays it on the LEDs.
- It then checks the player's presses one at a time and reports the round, points and game-end flags.
- It replaces the fixed 4-button, 64-bit shift-register compare with per-press early-fail checking, a configurable button count and depth, and a tick-based timeout.
- It sits between the button synchroniser, the slow-clock tick generator and the 7-segment display logic.

Parameters:
- N_BTN, 4, number of buttons/LEDs; must be a power of two, 2..16. BW = clog2(N_BTN).
- DEPTH, 16, maximum sequence length; reaching it means a win. RW = clog2(DEPTH+1).
- TIMEOUT_TICKS, 5, ticks allowed between user presses before a loss.
- PTS_W, 8, points counter width.

Ports:
- CLOCK_50  in  1  system clock; all state changes on the rising edge.
- R  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; begins a new game.
- seed  in  16  LFSR seed, sampled on an accepted start.
- tick  in  1  one-cycle enable from the slow clock; paces playback and timeout.
- btn_press  in  N_BTN  synchronised press pulses, one cycle per press.
- leds  out  N_BTN  one-hot playback display.
- round  out  RW  current sequence length.
- points  out  PTS_W  completed rounds, saturating at all-ones.
- end_FPGA  out  1  one-cycle pulse when playback finishes.
- end_User  out  1  one-cycle pulse when the user completes a round correctly.
- match  out  1  one-cycle pulse, coincident with end_User.
- end_time  out  1  level: lost by timeout.
- win  out  1  level: DEPTH rounds completed.
- lose  out  1  level: lost by wrong press or timeout.

Behaviour:
- **Registered outputs.** All outputs are registered. While R=0, every output is 0, the state is IDLE and the sequence memory is don't-care. Reset asserted mid-game aborts immediately.
- **Storage.** seq is DEPTH entries of BW bits.
- **LFSR.** 16-bit Galois, taps 0xB400, shift right. If the sampled seed is 0, 0xACE1 is loaded instead.
- **Step value.** The new step value is lfsr[BW-1:0] taken before the advance.
- **Accepting start.** start is honoured only in IDLE, WIN or LOSE. An accepted start loads the LFSR, sets round=0 and points=0, clears win/lose/end_time, then goes to GEN. start in any other state is ignored.
- **GEN (1 cycle).** Write seq[round] = step value, advance the LFSR, round += 1, playback index k = 0, then go to SHOW_ON.
- **SHOW_ON.** leds = onehot(seq[k]). On tick, go to SHOW_OFF with leds = 0.
- **SHOW_OFF.** On tick:
  - if k == round-1: pulse end_FPGA, set user index u = 0 and timeout count t = 0, go to WAIT_USER;
  - otherwise k += 1 and go to SHOW_ON.
- **Presses outside WAIT_USER.** btn_press is ignored in every state except WAIT_USER.
- **WAIT_USER, press present (btn_press != 0).**
  - The press is correct only if btn_press == onehot(seq[u]). A multi-hot press is wrong.
  - Correct press with u < round-1: u += 1, t = 0.
  - Correct press with u == round-1: pulse end_User and match, points += 1 (saturating). Then go to WIN if round == DEPTH, else to GEN.
  - Wrong press: set lose and go to LOSE.
- **WAIT_USER, tick with no press.** t += 1. When t reaches TIMEOUT_TICKS, set end_time and lose, then go to LOSE.
- **Press and tick in the same cycle.** The press takes priority and t is cleared.
- **WIN / LOSE.** Terminal states. leds = 0; round, points and flags hold until the next accepted start.
- **Width rules.**
  - round never exceeds DEPTH.
  - k and u range over 0..round-1.
  - t is sized for TIMEOUT_TICKS.
- **Latency.**
  - start to first LED on: 2 cycles (accept, then GEN).
  - Last correct press to next GEN: 1 cycle.

Test Plan:
- **Playback order.** N_BTN=4, DEPTH=4, TIMEOUT_TICKS=3, seed=0xACE1, start, then tick every 4 cycles.
  - Required: round=1, leds=0001'b shifted to 0010 (button 1).
  - Required: end_FPGA pulses after the second tick.
  - Required: the four-round sequence is 1,0,0,0.
- **Full game to win.** Answer every round correctly.
  - Required: end_User and match pulse 4 times and points = 1,2,3,4.
  - Required: win=1 with round=4, and leds stay 0 afterwards.
- **Wrong press.** In round 2, press button 3 as the first step.
  - Required: lose=1, end_time=0, points=1, no end_User.
  - Required: start then restarts with points=0.
- **Timeout and priority.** In WAIT_USER, apply 3 ticks with no press.
  - Required: end_time=1 and lose=1.
  - Repeat with a correct press landing in the same cycle as the 3rd tick. Required: no timeout, t cleared.
- **Illegal input and ignored events.** Apply a multi-hot press 0011 in WAIT_USER, then start pulses and presses during SHOW_ON.
  - Required: the multi-hot press gives lose.
  - Required: start and presses during SHOW_ON cause no state change.
- **Reset and zero seed.** Drive R low mid-SHOW_ON, then start with seed=0.
  - Required: all outputs are 0 immediately on R low, with no clock edge needed.
  - Required: after the seed=0 start, the sequence equals the 0xACE1 sequence.
